// File: rtl/memd_resp.sv
// Data-memory load responder: tagged loads queue in order and answer after a fixed latency.
// Optional store port enabled by defining MEMD_STORE_EN.
module memd_resp #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 2,
    parameter int TAG_W   = 2,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid
    // must not depend on ready, and the sender holds its payload until the transfer.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag
`ifdef MEMD_STORE_EN
    ,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WORDS = 1 << ADDR_W;
    localparam int CW    = PTR_W + 1;
    localparam logic [PTR_W:0]   FULL     = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    logic [DATA_W-1:0] memd_q     [WORDS];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [TAG_W-1:0]  ent_tag_q  [DEPTH];
    logic [CNT_W-1:0]  ent_cnt_q  [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push, pop;

    assign req_ready  = (count_q < FULL);
    assign resp_valid = (count_q != '0) && (ent_cnt_q[head_q] == '0);
    assign resp_data  = resp_valid ? ent_data_q[head_q] : '0;
    assign resp_tag   = resp_valid ? ent_tag_q[head_q] : '0;

    // Flush wins over both handshakes on the same edge.
    assign push = req_valid && req_ready && !flush;
    assign pop  = resp_valid && resp_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) memd_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_data_q[i] <= '0;
                ent_tag_q[i]  <= '0;
                ent_cnt_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Free-running saturating countdown; idle slots sit at 0 and are rewritten on push.
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_cnt_q[i] != '0) ent_cnt_q[i] <= ent_cnt_q[i] - 1'b1;
            end
            if (push) begin
                ent_data_q[tail_q] <= memd_q[req_addr];
                ent_tag_q[tail_q]  <= req_tag;
                ent_cnt_q[tail_q]  <= CNT_INIT;
            end
`ifdef MEMD_STORE_EN
            if (st_en) memd_q[st_addr] <= st_data;
`endif
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_memd_resp.sv
// Directed bench for memd_resp: latency, fill/drain order, backpressure, flush, reset, stores.
module tb_memd_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [1:0] req_tag;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] resp_data;
    logic [1:0] resp_tag;
`ifdef MEMD_STORE_EN
    logic       st_en;
    logic [1:0] st_addr;
    logic [3:0] st_data;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] mem_exp [4];
    logic [5:0] exp_q [$];
    logic [5:0] exp_item;

    memd_resp dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
`ifdef MEMD_STORE_EN
        ,
        .st_en      (st_en),
        .st_addr    (st_addr),
        .st_data    (st_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; resp_ready = 1'b0;
`ifdef MEMD_STORE_EN
        st_en = 1'b0; st_addr = '0; st_data = '0;
`endif
        for (int i = 0; i < 4; i++) mem_exp[i] = '0;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_resp_tag", 32'(resp_tag), 0);
        check("rst_count", 32'(dut.count_q), 0);
        rst = 1'b0;

        // single load: valid exactly one cycle, LATENCY edges after accept
        req_valid = 1'b1; req_addr = 2'd1; req_tag = 2'd2; resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("single_early", 32'(resp_valid), 0);
        step();
        check("single_valid", 32'(resp_valid), 1);
        check("single_data", 32'(resp_data), 0);
        check("single_tag", 32'(resp_tag), 2);
        step();
        check("single_after", 32'(resp_valid), 0);
        check("single_empty", 32'(dut.count_q), 0);

`ifdef MEMD_STORE_EN
        st_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_addr = 2'(i); st_data = 4'(5 + i);
            step();
            mem_exp[i] = 4'(5 + i);
        end
        st_en = 1'b0;
`endif

        // fill with the sink stalled
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 2'(3 - i); req_tag = 2'(i);
            step();
            check("fill_ready", 32'(req_ready), (i < 3) ? 1 : 0);
        end
        req_addr = 2'd0; req_tag = 2'd3;
        step();
        check("fill_5th_count", 32'(dut.count_q), 4);
        check("fill_5th_ready", 32'(req_ready), 0);
        req_valid = 1'b0;

        // drain in acceptance order on consecutive cycles
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), mem_exp[3 - i]});
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_item = exp_q.pop_front();
            check("drain", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, exp_item});
            step();
        end
        check("drain_done_valid", 32'(resp_valid), 0);
        check("drain_done_ready", 32'(req_ready), 1);

        // backpressure: head holds, second entry counts down behind it
        resp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 2'd1; req_tag = 2'd1;
        step();
        req_addr = 2'd2; req_tag = 2'd2;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 2'd1, mem_exp[1]});
            if (i < 2) step();
        end
        resp_ready = 1'b1;
        step();
        check("bp_next", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 2'd2, mem_exp[2]});
        step();
        check("bp_empty", 32'(resp_valid), 0);

        // flush with three outstanding and a request/pop on the flush edge
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 2'(i); req_tag = 2'(i);
            step();
        end
        req_addr = 2'd3; req_tag = 2'd3; flush = 1'b1; resp_ready = 1'b1;
        step();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_valid", 32'(resp_valid), 0);
        check("flush_count", 32'(dut.count_q), 0);
        check("flush_ready", 32'(req_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_quiet", 32'(resp_valid), 0);
        end
        req_valid = 1'b1; req_addr = 2'd3; req_tag = 2'd1;
        step();
        req_valid = 1'b0;
        step();
        check("post_flush", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 2'd1, mem_exp[3]});
        step();

`ifdef MEMD_STORE_EN
        // store and load to the same address on one edge: load sees old value
        st_en = 1'b1; st_addr = 2'd2; st_data = 4'd4;
        step();
        st_data = 4'd9; req_valid = 1'b1; req_addr = 2'd2; req_tag = 2'd3;
        step();
        st_en = 1'b0; req_valid = 1'b0;
        step();
        check("st_ld_old", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 2'd3, 4'd4});
        step();
        req_valid = 1'b1; req_addr = 2'd2; req_tag = 2'd0;
        step();
        req_valid = 1'b0;
        step();
        check("st_ld_new", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 2'd0, 4'd9});
        step();
`endif

        // reset mid-operation discards entries and clears memd
        resp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 2'd1; req_tag = 2'd1;
        step();
        req_addr = 2'd2; req_tag = 2'd2;
        step();
        req_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; resp_ready = 1'b1;
        check("midrst_count", 32'(dut.count_q), 0);
        check("midrst_valid", 32'(resp_valid), 0);
        step();
        check("midrst_quiet", 32'(resp_valid), 0);
        req_valid = 1'b1; req_addr = 2'd3; req_tag = 2'd2;
        step();
        req_valid = 1'b0;
        step();
        check("midrst_load", {25'd0, resp_valid, resp_tag, resp_data}, {25'd0, 1'b1, 2'd2, 4'd0});
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
